// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the ALU issue controller.
package alu_pkg;

  localparam logic [3:0] OP_INC  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUBB = 4'h2;
  localparam logic [3:0] OP_DEC  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_CLR  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: one synchronous write port, two operand reads and one
// debug read, all asynchronous; contents clear on reset.
module alu_regfile #(
  parameter int DATA_W  = 4,
  parameter int REG_CNT = 4,
  localparam int SEL_W  = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [SEL_W-1:0]  wr_sel_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [SEL_W-1:0]  ra_sel_i,
  output logic [DATA_W-1:0] ra_data_o,
  input  logic [SEL_W-1:0]  rb_sel_i,
  output logic [DATA_W-1:0] rb_data_o,
  input  logic [SEL_W-1:0]  dbg_sel_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] regs_q [REG_CNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) regs_q[i] <= '0;
    end else if (wr_en_i) begin
      regs_q[wr_sel_i] <= wr_data_i;
    end
  end

  assign ra_data_o  = regs_q[ra_sel_i];
  assign rb_data_o  = regs_q[rb_sel_i];
  assign dbg_data_o = regs_q[dbg_sel_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command-side controller for a registered ALU: latches operands, issues one
// enabled ALU cycle, writes the result back and pulses a response.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int REG_CNT = 4,
  localparam int SEL_W  = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [SEL_W-1:0]  cmd_rd,
  input  logic [SEL_W-1:0]  cmd_ra,
  input  logic [SEL_W-1:0]  cmd_rb,
  input  logic              cmd_cin,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_c_in,
  output logic [3:0]        alu_op,
  output logic              alu_en,
  input  logic [DATA_W-1:0] alu_y,
  output logic              rsp_valid,
  output logic [SEL_W-1:0]  rsp_rd,
  output logic [DATA_W-1:0] rsp_data,
  input  logic [SEL_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state_q;
  logic [SEL_W-1:0]  rd_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic              alu_c_in_q, alu_en_q;
  logic [3:0]        alu_op_q;
  logic              rsp_valid_q;
  logic [SEL_W-1:0]  rsp_rd_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic              accept, is_ldi;
  logic              wr_en_d;
  logic [SEL_W-1:0]  wr_sel_d;
  logic [DATA_W-1:0] wr_data_d;
  logic [DATA_W-1:0] ra_data, rb_data;

  assign cmd_ready = (state_q == S_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign is_ldi    = (cmd_op == OP_LDI);

  // Single write port shared by load-immediate (from IDLE) and ALU writeback (WB)
  always_comb begin
    wr_en_d   = 1'b0;
    wr_sel_d  = rd_q;
    wr_data_d = alu_y;
    if (state_q == S_WB) begin
      wr_en_d = 1'b1;
    end else if (accept && is_ldi) begin
      wr_en_d   = 1'b1;
      wr_sel_d  = cmd_rd;
      wr_data_d = cmd_imm;
    end
  end

  alu_regfile #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en_d),
    .wr_sel_i   (wr_sel_d),
    .wr_data_i  (wr_data_d),
    .ra_sel_i   (cmd_ra),
    .ra_data_o  (ra_data),
    .rb_sel_i   (cmd_rb),
    .rb_data_o  (rb_data),
    .dbg_sel_i  (dbg_sel),
    .dbg_data_o (dbg_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_c_in_q  <= 1'b0;
      alu_op_q    <= '0;
      alu_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rd_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      alu_en_q    <= 1'b0;
      rsp_valid_q <= wr_en_d;
      if (wr_en_d) begin
        rsp_rd_q   <= wr_sel_d;
        rsp_data_q <= wr_data_d;
      end
      case (state_q)
        S_IDLE: begin
          // Operands are captured here, so rd aliasing ra/rb is harmless
          if (accept && !is_ldi) begin
            alu_a_q    <= ra_data;
            alu_b_q    <= rb_data;
            alu_op_q   <= cmd_op;
            alu_c_in_q <= cmd_cin;
            rd_q       <= cmd_rd;
            alu_en_q   <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: state_q <= S_WB;
        S_WB:    state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_c_in  = alu_c_in_q;
  assign alu_op    = alu_op_q;
  assign alu_en    = alu_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural registered ALU alongside it and a
// register-file reference model.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_cin;
  logic [3:0] cmd_op, cmd_imm;
  logic [1:0] cmd_rd, cmd_ra, cmd_rb;
  logic [3:0] alu_a, alu_b, alu_op;
  logic       alu_c_in, alu_en;
  logic [3:0] alu_y = 4'h0;
  logic       rsp_valid;
  logic [1:0] rsp_rd;
  logic [3:0] rsp_data;
  logic [1:0] dbg_sel;
  logic [3:0] dbg_data;

  int errors = 0;
  int checks = 0;
  logic [3:0] model_rf [4];

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_cin(cmd_cin), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in), .alu_op(alu_op),
    .alu_en(alu_en), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .rsp_data(rsp_data),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  function automatic logic [3:0] ref_alu(input logic [3:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input logic cin);
    logic [3:0] c;
    c = {3'b000, cin};
    case (op)
      4'h0: return a + 4'd1;
      4'h1: return a + b + c;
      4'h2: return a - b - c;
      4'h3: return a - 4'd1;
      4'h4: return a & b;
      4'h5: return a | b;
      4'h6: return a ^ b;
      4'h7: return ~a;
      default: return 4'h0;
    endcase
  endfunction

  // Registered ALU: y updates on the enabled edge only
  always_ff @(posedge clk)
    if (alu_en) alu_y <= ref_alu(alu_op, alu_a, alu_b, alu_c_in);

  task automatic clear_model();
    for (int i = 0; i < 4; i++) model_rf[i] = 4'h0;
  endtask

  task automatic exec_ldi(input logic [1:0] rd, input logic [3:0] imm);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL ldi_ready got=%b exp=1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = 4'hF; cmd_rd = rd; cmd_imm = imm;
    cmd_ra = 2'($urandom_range(0, 3)); cmd_rb = 2'($urandom_range(0, 3));
    @(negedge clk);
    cmd_valid = 1'b0;
    model_rf[rd] = imm;
    checks++;
    if ({rsp_valid, rsp_rd, rsp_data} !== {1'b1, rd, imm}) begin
      errors++;
      $display("FAIL ldi_rsp got=%b/%0d/%h exp=1/%0d/%h", rsp_valid, rsp_rd, rsp_data, rd, imm);
    end
  endtask

  task automatic exec_alu(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                          input logic [1:0] rb, input logic cin);
    logic [3:0] exp_y, old;
    exp_y = ref_alu(op, model_rf[ra], model_rf[rb], cin);
    old = model_rf[rd];
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_cin = cin;
    cmd_imm = 4'($urandom_range(0, 15));
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({alu_en, cmd_ready, alu_a, alu_b, alu_op, alu_c_in} !==
        {1'b1, 1'b0, model_rf[ra], model_rf[rb], op, cin}) begin
      errors++;
      $display("FAIL issue en=%b rdy=%b a=%h b=%h op=%h c=%b exp en=1 rdy=0 a=%h b=%h op=%h c=%b",
               alu_en, cmd_ready, alu_a, alu_b, alu_op, alu_c_in, model_rf[ra], model_rf[rb], op, cin);
    end
    dbg_sel = rd;
    @(negedge clk);
    checks++;
    if ({alu_en, cmd_ready, rsp_valid, dbg_data} !== {1'b0, 1'b0, 1'b0, old}) begin
      errors++;
      $display("FAIL wb_cycle en=%b rdy=%b rsp=%b dbg=%h exp 0/0/0/%h",
               alu_en, cmd_ready, rsp_valid, dbg_data, old);
    end
    @(negedge clk);
    model_rf[rd] = exp_y;
    checks++;
    if ({rsp_valid, rsp_rd, rsp_data, cmd_ready, dbg_data} !== {1'b1, rd, exp_y, 1'b1, exp_y}) begin
      errors++;
      $display("FAIL alu_rsp got=%b/%0d/%h rdy=%b dbg=%h exp=1/%0d/%h rdy=1 dbg=%h",
               rsp_valid, rsp_rd, rsp_data, cmd_ready, dbg_data, rd, exp_y, exp_y);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_op = 4'h1;
    #1;
    checks++;
    if ({alu_en, rsp_valid, alu_a, alu_b, alu_op, alu_c_in} !== 15'h0) begin
      errors++;
      $display("FAIL reset_outputs en=%b rsp=%b a=%h b=%h op=%h c=%b exp all 0",
               alu_en, rsp_valid, alu_a, alu_b, alu_op, alu_c_in);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;
    clear_model();
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      checks++;
      if (dbg_data !== 4'h0) begin
        errors++; $display("FAIL reset_reg%0d got=%h exp=0", i, dbg_data);
      end
    end
  endtask

  task automatic test_ldi();
    @(negedge clk);
    exec_ldi(2'd0, 4'h5);
    exec_ldi(2'd1, 4'h3);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL ldi_idle_rsp got=%b exp=0", rsp_valid);
    end
    dbg_sel = 2'd0; #1;
    checks++;
    if (dbg_data !== 4'h5) begin errors++; $display("FAIL ldi_dbg_r0 got=%h exp=5", dbg_data); end
    dbg_sel = 2'd1; #1;
    checks++;
    if (dbg_data !== 4'h3) begin errors++; $display("FAIL ldi_dbg_r1 got=%h exp=3", dbg_data); end
  endtask

  task automatic test_add();
    @(negedge clk);
    exec_alu(4'h1, 2'd2, 2'd0, 2'd1, 1'b1);
    checks++;
    if (rsp_data !== 4'h9) begin errors++; $display("FAIL add_value got=%h exp=9", rsp_data); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    exec_ldi(2'd0, 4'hF);
    exec_alu(4'h0, 2'd0, 2'd0, 2'd1, 1'b1);
    dbg_sel = 2'd0; #1;
    checks++;
    if (dbg_data !== 4'h0) begin errors++; $display("FAIL wrap_inc got=%h exp=0", dbg_data); end
    @(negedge clk);
    exec_alu(4'h3, 2'd3, 2'd3, 2'd0, 1'b0);
    dbg_sel = 2'd3; #1;
    checks++;
    if (dbg_data !== 4'hF) begin errors++; $display("FAIL wrap_dec got=%h exp=F", dbg_data); end
  endtask

  task automatic test_busy();
    logic [3:0] exp_a, exp_c;
    @(negedge clk);
    exec_ldi(2'd1, 4'h6);
    exec_ldi(2'd2, 4'hA);
    exp_a = ref_alu(4'h1, model_rf[2], model_rf[1], 1'b0);
    cmd_valid = 1'b1; cmd_op = 4'h1; cmd_rd = 2'd3; cmd_ra = 2'd2; cmd_rb = 2'd1; cmd_cin = 1'b0;
    @(negedge clk);
    checks++;
    if ({alu_en, alu_op} !== {1'b1, 4'h1}) begin
      errors++; $display("FAIL busy_issue en=%b op=%h exp=1/1", alu_en, alu_op);
    end
    cmd_op = 4'h6; cmd_rd = 2'd1; cmd_ra = 2'd0; cmd_rb = 2'd2; cmd_cin = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, alu_en, alu_op, alu_a} !== {1'b0, 1'b0, 4'h1, model_rf[2]}) begin
      errors++;
      $display("FAIL busy_hold rdy=%b en=%b op=%h a=%h exp=0/0/1/%h", cmd_ready, alu_en, alu_op, alu_a, model_rf[2]);
    end
    cmd_op = 4'h5; cmd_rd = 2'd0; cmd_ra = 2'd2; cmd_rb = 2'd3; cmd_cin = 1'b0;
    @(negedge clk);
    model_rf[3] = exp_a;
    checks++;
    if ({rsp_valid, rsp_rd, rsp_data, cmd_ready} !== {1'b1, 2'd3, exp_a, 1'b1}) begin
      errors++;
      $display("FAIL busy_rsp got=%b/%0d/%h rdy=%b exp=1/3/%h rdy=1", rsp_valid, rsp_rd, rsp_data, cmd_ready, exp_a);
    end
    exp_c = ref_alu(4'h5, model_rf[2], model_rf[3], 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({alu_en, alu_op, alu_a, alu_b} !== {1'b1, 4'h5, model_rf[2], model_rf[3]}) begin
      errors++;
      $display("FAIL busy_next en=%b op=%h a=%h b=%h exp=1/5/%h/%h", alu_en, alu_op, alu_a, alu_b, model_rf[2], model_rf[3]);
    end
    repeat (2) @(negedge clk);
    model_rf[0] = exp_c;
    checks++;
    if ({rsp_valid, rsp_rd, rsp_data} !== {1'b1, 2'd0, exp_c}) begin
      errors++; $display("FAIL busy_next_rsp got=%b/%0d/%h exp=1/0/%h", rsp_valid, rsp_rd, rsp_data, exp_c);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF)
        exec_ldi(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      else
        exec_alu(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_issue();
    @(negedge clk);
    exec_ldi(2'd0, 4'h7);
    exec_ldi(2'd1, 4'h4);
    cmd_valid = 1'b1; cmd_op = 4'h1; cmd_rd = 2'd3; cmd_ra = 2'd0; cmd_rb = 2'd1; cmd_cin = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (alu_en !== 1'b1) begin errors++; $display("FAIL rsti_issue en=%b exp=1", alu_en); end
    rst = 1'b1; #1;
    checks++;
    if ({alu_en, rsp_valid} !== 2'b00) begin
      errors++; $display("FAIL rsti_async en=%b rsp=%b exp=0/0", alu_en, rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, alu_en, cmd_ready} !== 3'b001) begin
        errors++; $display("FAIL rsti_quiet%0d rsp=%b en=%b rdy=%b exp=0/0/1", i, rsp_valid, alu_en, cmd_ready);
      end
    end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      checks++;
      if (dbg_data !== 4'h0) begin errors++; $display("FAIL rsti_reg%0d got=%h exp=0", i, dbg_data); end
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_rd = 2'd0; cmd_ra = 2'd0;
    cmd_rb = 2'd0; cmd_cin = 1'b0; cmd_imm = 4'h0; dbg_sel = 2'd0;
    clear_model();
    test_reset();
    test_ldi();
    test_add();
    test_wrap();
    test_reset();
    test_busy();
    test_random();
    test_reset_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
